// File: rtl/multiphase_clkgen.sv
// Multi-phase clock generator: a JW-bit Johnson counter advanced by a programmable
// prescaler gives 2*JW equally spaced 50%-duty phases with glitch-free start and stop.
module multiphase_clkgen #(
    parameter int JW    = 2,
    parameter int DIV_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    output logic [2*JW-1:0]   ph,
    output logic              sof,
    output logic              running,
    output logic [DIV_W-1:0]  div_act
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [JW-1:0] J_LAST = {1'b1, {(JW-1){1'b0}}};

    state_t            r_state;
    logic [JW-1:0]     r_j;
    logic [DIV_W-1:0]  r_pre;
    logic [DIV_W-1:0]  r_div_q;
    logic              r_sof;
    logic              r_running;

    logic              w_tick;
    logic              w_bound;
    logic [JW-1:0]     w_j_next;

    assign w_tick   = (r_state != IDLE) && (r_pre == r_div_q);
    assign w_bound  = w_tick && (r_j == J_LAST);
    assign w_j_next = {r_j[JW-2:0], ~r_j[JW-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_j       <= '0;
            r_pre     <= '0;
            r_div_q   <= '0;
            r_sof     <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_sof <= w_tick && (r_j == '0);
            if (r_state == IDLE) begin
                r_j   <= '0;
                r_pre <= '0;
                if (en) begin
                    r_state   <= RUN;
                    r_div_q   <= div;
                    r_running <= 1'b1;
                end
            end else begin
                if (w_tick) begin
                    r_j   <= w_j_next;
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
                case (r_state)
                    RUN: begin
                        if (w_bound)
                            r_div_q <= div;
                        if (!en)
                            r_state <= STOP;
                    end
                    STOP: begin
                        // A stop request only takes effect once the period closes at j==0.
                        if (en) begin
                            r_state <= RUN;
                            if (w_bound)
                                r_div_q <= div;
                        end else if (w_bound) begin
                            r_state   <= IDLE;
                            r_running <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Low half of the phases are counter bits, high half their single inversions.
    assign ph      = {~r_j, r_j};
    assign sof     = r_sof;
    assign running = r_running;
    assign div_act = r_div_q;

endmodule

// File: tb/tb_multiphase_clkgen.sv
// Directed bench for multiphase_clkgen: JW=2 and JW=3 instances checked against
// hand-computed phase sequences cycle by cycle.
module tb_multiphase_clkgen;

    logic        clk;
    logic        rst;
    logic        en2, en3;
    logic [3:0]  div2, div3;
    logic [3:0]  ph2;
    logic [5:0]  ph3;
    logic        sof2, sof3, running2, running3;
    logic [3:0]  div_act2, div_act3;

    int n_chk;
    int n_fail;

    multiphase_clkgen #(.JW(2), .DIV_W(4)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .div(div2),
        .ph(ph2), .sof(sof2), .running(running2), .div_act(div_act2)
    );

    multiphase_clkgen #(.JW(3), .DIV_W(4)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .div(div3),
        .ph(ph3), .sof(sof3), .running(running3), .div_act(div_act3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [3:0] tbl1 [4]  = '{4'h9, 4'h3, 4'h6, 4'hC};
    logic [3:0] tbl3 [10] = '{4'hC, 4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'hC};
    logic [3:0] tbl5 [12] = '{4'hC, 4'h9, 4'h9, 4'h3, 4'h3, 4'h6, 4'h6, 4'hC, 4'hC, 4'h9, 4'h9, 4'h3};
    logic [5:0] tbl2 [6]  = '{6'h38, 6'h31, 6'h23, 6'h07, 6'h0E, 6'h1C};

    initial begin
        logic [3:0] e4;
        n_chk  = 0;
        n_fail = 0;
        en2 = 1'b0; en3 = 1'b0; div2 = 4'd0; div3 = 4'd0;
        rst = 1'b1;
        #2;
        chk("rst_ph", 32'(ph2), 32'hC);
        chk("rst_sof", 32'(sof2), 32'h0);
        chk("rst_running", 32'(running2), 32'h0);
        chk("rst_div_act", 32'(div_act2), 32'h0);
        chk("rst_ph3", 32'(ph3), 32'h38);

        // div=0 basic sequence
        step();
        rst = 1'b0;
        en2 = 1'b1;
        div2 = 4'd0;
        step();
        chk("t1_e0_ph", 32'(ph2), 32'hC);
        chk("t1_e0_running", 32'(running2), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("t1_ph", 32'(ph2), 32'(tbl1[(i-1)%4]));
            chk("t1_sof", 32'(sof2), 32'(i % 4 == 1));
        end

        // Asynchronous reset mid-period, then restart with identical timing
        step();
        chk("t6_pre_ph", 32'(ph2), 32'h9);
        chk("t6_pre_sof", 32'(sof2), 32'h1);
        rst = 1'b1;
        #2;
        chk("t6_ph", 32'(ph2), 32'hC);
        chk("t6_sof", 32'(sof2), 32'h0);
        chk("t6_running", 32'(running2), 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t6_e0_ph", 32'(ph2), 32'hC);
        chk("t6_e0_running", 32'(running2), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("t6_ph_restart", 32'(ph2), 32'(tbl1[i-1]));
            chk("t6_sof_restart", 32'(sof2), 32'(i == 1));
        end

        // div=1, drop en while j=11: period completes, then idle
        en2 = 1'b0;
        reset_pulse();
        div2 = 4'd1;
        en2 = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t3_ph", 32'(ph2), 32'(tbl3[k-1]));
            chk("t3_running", 32'(running2), 32'(k < 8));
            if (k == 4) en2 = 1'b0;
        end
        chk("t3_div_act", 32'(div_act2), 32'h1);

        // div 0->3 mid-period with en held
        reset_pulse();
        div2 = 4'd0;
        en2 = 1'b1;
        step();
        for (int k = 1; k <= 24; k++) begin
            step();
            if (k <= 4)
                e4 = tbl1[k-1];
            else if (k < 8)  e4 = 4'hC;
            else if (k < 12) e4 = 4'h9;
            else if (k < 16) e4 = 4'h3;
            else if (k < 20) e4 = 4'h6;
            else if (k < 24) e4 = 4'hC;
            else             e4 = 4'h9;
            chk("t4_ph", 32'(ph2), 32'(e4));
            chk("t4_div_act", 32'(div_act2), (k < 4) ? 32'h0 : 32'h3);
            chk("t4_sof", 32'(sof2), 32'(k == 1 || k == 8 || k == 24));
            if (k == 2) div2 = 4'd3;
        end

        // One-cycle en drop while in STOP: no disturbance
        reset_pulse();
        div2 = 4'd1;
        en2 = 1'b1;
        step();
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("t5_ph", 32'(ph2), 32'(tbl5[k-1]));
            chk("t5_running", 32'(running2), 32'h1);
            chk("t5_sof", 32'(sof2), 32'(k == 2 || k == 10));
            if (k == 2) en2 = 1'b0;
            if (k == 3) en2 = 1'b1;
        end
        en2 = 1'b0;

        // JW=3, div=2: 18-cycle period, 3-cycle phase step
        reset_pulse();
        div3 = 4'd2;
        en3 = 1'b1;
        step();
        chk("t2_running", 32'(running3), 32'h1);
        chk("t2_div_act", 32'(div_act3), 32'h2);
        for (int k = 1; k <= 21; k++) begin
            step();
            chk("t2_ph", 32'(ph3), 32'(tbl2[(k/3)%6]));
            chk("t2_sof", 32'(sof3), 32'(k == 3 || k == 21));
        end
        en3 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
